// File: rtl/screen_painter.sv
// -----------------------------------------------------------------------------
// screen_painter
//
// Paints one full VGA frame into a vga_adapter, either by streaming one of
// NUM_SCREENS images stored back-to-back in a ROM, or with a single solid
// colour. One pixel is issued per cycle in raster order (x fastest). The ROM
// read latency is absorbed by a ROM_LATENCY-deep pipeline carrying x, y and a
// valid bit, so plot/x/y line up with the returning rom_data.
//
// Ports
//   CLOCK_50     in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start        in   single-cycle draw request (also aborts a running draw)
//   screen_sel   in   image index, must be < NUM_SCREENS
//   fill_mode    in   0 = ROM image, 1 = solid fill
//   fill_colour  in   solid fill colour
//   rom_addr     out  ROM read address
//   rom_data     in   ROM read data, ROM_LATENCY cycles after rom_addr
//   x, y         out  pixel coordinates to vga_adapter
//   colour       out  pixel colour to vga_adapter
//   plot         out  write strobe to vga_adapter
//   busy         out  draw in progress (DRAW, DRAIN and FINISH)
//   done         out  one-cycle completion pulse (the FINISH cycle)
//   err          out  one-cycle pulse for a request with an invalid screen_sel
// -----------------------------------------------------------------------------
module screen_painter #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int XW          = 8,
    parameter int YW          = 7,
    parameter int COLOUR_BITS = 3,
    parameter int NUM_SCREENS = 6,
    parameter int SEL_W       = 3,
    parameter int ADDR_W      = 17,
    parameter int ROM_LATENCY = 1
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [SEL_W-1:0]       screen_sel,
    input  logic                   fill_mode,
    input  logic [COLOUR_BITS-1:0] fill_colour,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [COLOUR_BITS-1:0] rom_data,
    output logic [XW-1:0]          x,
    output logic [YW-1:0]          y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int                PIX    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] PIX_A  = ADDR_W'(PIX);
    localparam logic [XW-1:0]     LAST_X = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     LAST_Y = YW'(HEIGHT - 1);
    localparam logic [2:0]        LAST_D = 3'(ROM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DRAIN,
        FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [XW-1:0]            cnt_x_q, cnt_x_d;
    logic [YW-1:0]            cnt_y_q, cnt_y_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [2:0]               drain_q, drain_d;
    logic                     fill_q, fill_d;
    logic [COLOUR_BITS-1:0]   fill_col_q, fill_col_d;
    logic [COLOUR_BITS-1:0]   colour_q, colour_d;
    logic                     err_q, err_d;

    // Coordinate/valid delay line matching the ROM read latency.
    logic                     vld_q [ROM_LATENCY];
    logic                     vld_d [ROM_LATENCY];
    logic [XW-1:0]            px_q  [ROM_LATENCY];
    logic [XW-1:0]            px_d  [ROM_LATENCY];
    logic [YW-1:0]            py_q  [ROM_LATENCY];
    logic [YW-1:0]            py_d  [ROM_LATENCY];

    logic                     sel_ok;
    logic                     accept;
    logic                     flush;
    logic                     issue;
    logic [COLOUR_BITS-1:0]   pix_colour;

    assign sel_ok = int'(screen_sel) < NUM_SCREENS;
    assign accept = start && sel_ok;
    // Any accepted request, including one that aborts a running draw, empties
    // the pipeline so no pixel of the old draw can reach the adapter.
    assign flush  = accept;
    assign issue  = (state_q == DRAW);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves
        // it unassigned -- otherwise synthesis infers a latch.
        state_d    = state_q;
        cnt_x_d    = cnt_x_q;
        cnt_y_d    = cnt_y_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        fill_d     = fill_q;
        fill_col_d = fill_col_q;
        err_d      = start && !sel_ok;

        unique case (state_q)
            IDLE: ;
            DRAW: begin
                if (cnt_x_q == LAST_X && cnt_y_q == LAST_Y) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (cnt_x_q == LAST_X) begin
                        cnt_x_d = '0;
                        cnt_y_d = cnt_y_q + 1'b1;
                    end else begin
                        cnt_x_d = cnt_x_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == LAST_D) state_d = FINISH;
                else                   drain_d = drain_q + 1'b1;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A valid request wins in every state: start, abort or back-to-back.
        // The base address multiply happens once per request, never per pixel.
        if (accept) begin
            state_d    = DRAW;
            cnt_x_d    = '0;
            cnt_y_d    = '0;
            addr_d     = ADDR_W'(screen_sel) * PIX_A;
            fill_d     = fill_mode;
            fill_col_d = fill_colour;
        end
    end

    // Pipeline stages load coordinates only from a valid source, so the last
    // stage naturally holds the most recently plotted x/y.
    always_comb begin
        for (int i = 0; i < ROM_LATENCY; i++) begin
            vld_d[i] = 1'b0;
            px_d[i]  = px_q[i];
            py_d[i]  = py_q[i];
        end
        vld_d[0] = issue && !flush;
        if (issue && !flush) begin
            px_d[0] = cnt_x_q;
            py_d[0] = cnt_y_q;
        end
        for (int i = 1; i < ROM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1] && !flush;
            if (vld_q[i-1] && !flush) begin
                px_d[i] = px_q[i-1];
                py_d[i] = py_q[i-1];
            end
        end
    end

    // rom_data arrives combinationally in the plot cycle; the colour register
    // only remembers it so colour can hold between plots.
    always_comb begin
        pix_colour = fill_q ? fill_col_q : rom_data;
        colour_d   = plot ? pix_colour : colour_q;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_x_q    <= '0;
            cnt_y_q    <= '0;
            addr_q     <= '0;
            drain_q    <= '0;
            fill_q     <= 1'b0;
            fill_col_q <= '0;
            colour_q   <= '0;
            err_q      <= 1'b0;
            // NOTE: the pipeline is a handful of flops, not a RAM, so it is
            // reset; the valid bits must be, or a stale plot could follow reset.
            for (int i = 0; i < ROM_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                px_q[i]  <= '0;
                py_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_x_q    <= cnt_x_d;
            cnt_y_q    <= cnt_y_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            fill_q     <= fill_d;
            fill_col_q <= fill_col_d;
            colour_q   <= colour_d;
            err_q      <= err_d;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                vld_q[i] <= vld_d[i];
                px_q[i]  <= px_d[i];
                py_q[i]  <= py_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr = addr_q;
    assign plot     = vld_q[ROM_LATENCY-1];
    assign x        = px_q[ROM_LATENCY-1];
    assign y        = py_q[ROM_LATENCY-1];
    assign colour   = plot ? pix_colour : colour_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FINISH);
    assign err      = err_q;

endmodule

// File: tb/tb_screen_painter.sv
// -----------------------------------------------------------------------------
// tb_screen_painter
//
// Scoreboard bench for screen_painter on a small 4x2 frame with a 2-cycle ROM.
// Each request is expanded into the frame it should produce (addresses, plots,
// done/err pulses, busy window), stamped with absolute cycle numbers; a monitor
// on the falling edge pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_screen_painter;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int L   = 2;
    localparam int NS  = 3;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int CB  = 3;
    localparam int SW  = 3;
    localparam int AW  = 17;
    localparam int PIX = W * H;

    logic          CLOCK_50 = 1'b0;
    logic          resetn;
    logic          start;
    logic [SW-1:0] screen_sel;
    logic          fill_mode;
    logic [CB-1:0] fill_colour;
    logic [AW-1:0] rom_addr;
    logic [CB-1:0] rom_data;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CB-1:0] colour;
    logic          plot, busy, done, err;

    screen_painter #(
        .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .COLOUR_BITS(CB),
        .NUM_SCREENS(NS), .SEL_W(SW), .ADDR_W(AW), .ROM_LATENCY(L)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .screen_sel (screen_sel),
        .fill_mode  (fill_mode),
        .fill_colour(fill_colour),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // ROM model: word = address mod 8, returned L cycles after the address.
    logic [AW-1:0] hist [L];
    always @(posedge CLOCK_50) begin
        hist[0] <= rom_addr;
        for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
    end
    assign rom_data = hist[L-1][CB-1:0];

    // Absolute cycle number: cycle n is the period after the n-th rising edge.
    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct { int cyc; int x; int y; int col; } pix_t;
    typedef struct { int cyc; int a; } adr_t;

    pix_t exp_plot [$];
    adr_t exp_addr [$];
    int   exp_done [$];
    int   exp_err  [$];
    int   busy_lo = 1, busy_hi = 0;
    int   last_x = 0, last_y = 0, last_col = 0;

    task automatic model_reset();
        exp_plot.delete();
        exp_addr.delete();
        exp_done.delete();
        exp_err.delete();
        busy_lo  = 1;
        busy_hi  = 0;
        last_x   = 0;
        last_y   = 0;
        last_col = 0;
    endtask

    // Presents one request in the current cycle and records what it must cause.
    task automatic issue(input int sel, input bit fm, input int fc);
        int c = cyc;
        int base;
        start       = 1'b1;
        screen_sel  = SW'(sel);
        fill_mode   = fm;
        fill_colour = CB'(fc);
        if (sel >= NS) begin
            exp_err.push_back(c + 1);
        end else begin
            // Everything of a previous draw scheduled after this cycle is cancelled.
            while (exp_plot.size() > 0 && exp_plot[$].cyc > c) void'(exp_plot.pop_back());
            while (exp_addr.size() > 0 && exp_addr[$].cyc > c) void'(exp_addr.pop_back());
            while (exp_done.size() > 0 && exp_done[$] > c) void'(exp_done.pop_back());
            base = sel * PIX;
            for (int p = 0; p < PIX; p++) begin
                exp_addr.push_back('{c + 1 + p, base + p});
                exp_plot.push_back('{c + 1 + L + p, p % W, p / W, fm ? fc : (base + p) % 8});
            end
            exp_done.push_back(c + 1 + L + PIX);
            if (c >= busy_lo && c <= busy_hi) busy_hi = c + 1 + L + PIX;
            else begin
                busy_lo = c + 1;
                busy_hi = c + 1 + L + PIX;
            end
        end
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        // Scramble request inputs: the draw in flight must not notice.
        screen_sel  = SW'($urandom);
        fill_mode   = 1'($urandom);
        fill_colour = CB'($urandom);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge CLOCK_50); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cyc <= busy_hi + 1 || exp_plot.size() > 0 || exp_done.size() > 0) && n < 200) begin
            wait_cycles(1);
            n++;
        end
        check("drain_timeout_plots", exp_plot.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"},        x, 0);
        check({tag, "_y"},        y, 0);
        check({tag, "_colour"},   colour, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_plot"},     plot, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_done"},     done, 0);
        check({tag, "_err"},      err, 0);
    endtask

    // ---------------- monitor ----------------
    bit mon_en = 1'b0;
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            pix_t e;
            adr_t a;
            logic exp_d, exp_e;
            if (plot) begin
                if (exp_plot.size() == 0) begin
                    check("unexpected_plot", plot, 1'b0);
                end else begin
                    e = exp_plot.pop_front();
                    check("plot_cycle",  cyc, e.cyc);
                    check("plot_x",      x, e.x);
                    check("plot_y",      y, e.y);
                    check("plot_colour", colour, e.col);
                    last_x   = e.x;
                    last_y   = e.y;
                    last_col = e.col;
                end
            end else begin
                while (exp_plot.size() > 0 && exp_plot[0].cyc <= cyc) begin
                    e = exp_plot.pop_front();
                    check("plot_missing", plot, 1'b1);
                end
                check("hold_x",      x, last_x);
                check("hold_y",      y, last_y);
                check("hold_colour", colour, last_col);
            end
            if (exp_addr.size() > 0 && exp_addr[0].cyc == cyc) begin
                a = exp_addr.pop_front();
                check("rom_addr", rom_addr, a.a);
            end
            exp_d = (exp_done.size() > 0 && exp_done[0] == cyc);
            if (exp_d) void'(exp_done.pop_front());
            check("done", done, exp_d);
            exp_e = (exp_err.size() > 0 && exp_err[0] == cyc);
            if (exp_e) void'(exp_err.pop_front());
            check("err", err, exp_e);
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        screen_sel  = '0;
        fill_mode   = 1'b0;
        fill_colour = '0;
        #2;
        check_all_zero("reset");
        wait_cycles(3);
        resetn = 1'b1;
        mon_en = 1'b1;
        wait_cycles(2);

        // ROM image, screen 1.
        issue(1, 1'b0, 0);
        wait_idle();

        // Solid fill colour 5.
        issue(0, 1'b1, 5);
        wait_idle();

        // Invalid screen: err only.
        issue(3, 1'b0, 0);
        wait_cycles(4);

        // Abort at cycle 4 with screen 2.
        issue(0, 1'b0, 0);
        wait_cycles(3);
        issue(2, 1'b0, 0);
        wait_idle();

        // Invalid request while busy leaves the draw running.
        issue(1, 1'b1, 6);
        wait_cycles(2);
        issue(5, 1'b0, 0);
        wait_idle();

        // Reset at cycle 5 of a draw.
        issue(2, 1'b0, 0);
        wait_cycles(4);
        resetn = 1'b0;
        model_reset();
        #1;
        check_all_zero("mid_reset");
        wait_cycles(2);
        resetn = 1'b1;
        wait_cycles(12);

        // New request in the FINISH cycle.
        issue(1, 1'b0, 0);
        wait_cycles(1 + L + PIX - 1);
        check("finish_cycle_done", done, 1'b1);
        issue(0, 1'b1, 3);
        wait_idle();

        // Randomised requests, gaps and aborts.
        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 4), 1'($urandom), $urandom_range(0, 7));
            wait_cycles($urandom_range(0, 14));
        end
        wait_idle();
        wait_cycles(3);

        check("left_addr", exp_addr.size(), 0);
        check("left_done", exp_done.size(), 0);
        check("left_err",  exp_err.size(), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
